peak_reader: RTL and testbench

- Consumer end of the spectral peak path: captures each frame's peak set (time counter plus PEAKS amplitude/frequency pairs) on a one-cycle strobe.
- Buffers up to DEPTH frames and lets the HPS drain them word by word over an Avalon-MM slave read port.
- Sits between the peak detector and the lightweight HPS bridge; raises irq while data is pending.

---
 rtl/peaks_pkg.sv | 39 +++
 rtl/peak_frame_fifo.sv | 52 +++++
 rtl/peak_reader.sv | 88 ++++++++
 tb/tb_peak_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/peaks_pkg.sv
// Shared parameters, frame type and word packing for the spectral peak read path.
package peaks_pkg;

  localparam int unsigned PEAKS  = 6;
  localparam int unsigned AMPL_W = 16;
  localparam int unsigned FREQ_W = 10;
  localparam int unsigned TIME_W = 24;
  localparam int unsigned DEPTH  = 4;

  localparam int unsigned FRAME_WORDS = PEAKS + 1;
  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam int unsigned IDX_W       = $clog2(FRAME_WORDS);

  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_DATA   = 1'b1;

  typedef struct packed {
    logic [TIME_W-1:0]             counter;
    logic [PEAKS-1:0][AMPL_W-1:0]  ampl;
    logic [PEAKS-1:0][FREQ_W-1:0]  freq;
  } peak_frame_t;

  // Word 0 is the time counter; word k carries band k-1 as {freq, ampl}.
  function automatic logic [31:0] pack_word(peak_frame_t frame, logic [IDX_W-1:0] index);
    logic [31:0]      word;
    logic [IDX_W-1:0] band;
    word = '0;
    band = index - IDX_W'(1);
    if (index == '0) begin
      word[TIME_W-1:0] = frame.counter;
    end else if (index <= IDX_W'(PEAKS)) begin
      word[AMPL_W-1:0]              = frame.ampl[band];
      word[AMPL_W+FREQ_W-1:AMPL_W]  = frame.freq[band];
    end
    return word;
  endfunction

endpackage

// File: rtl/peak_frame_fifo.sv
// Frame buffer of DEPTH peak sets; a push while full is accepted only if a pop frees a slot.
module peak_frame_fifo
  import peaks_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  peak_frame_t      wdata_i,
  output peak_frame_t      rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  peak_frame_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CNT_W'(DEPTH));
    count_o = count_q;
    rdata_o = mem_q[rd_ptr_q];
    rd_en   = pop_i && !empty_o;
    wr_en   = push_i && (!full_o || rd_en);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/peak_reader.sv
// Captures peak frames on a strobe and lets the HPS drain them word by word over Avalon-MM.
module peak_reader
  import peaks_pkg::*;
(
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           peak_valid,
  input  logic [PEAKS-1:0][AMPL_W-1:0]   amplitudes_in,
  input  logic [PEAKS-1:0][FREQ_W-1:0]   freqs_in,
  input  logic [TIME_W-1:0]              counter_in,
  input  logic                           chipselect,
  input  logic                           read,
  input  logic                           address,
  output logic [31:0]                    readdata,
  output logic                           irq
);

  peak_frame_t      wframe, head;
  logic             full, empty, pop;
  logic [CNT_W-1:0] count;
  logic             rd_req, status_rd, data_rd, drop;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;

  always_comb begin
    wframe.counter = counter_in;
    wframe.ampl    = amplitudes_in;
    wframe.freq    = freqs_in;
  end

  peak_frame_fifo u_fifo (
    .clk_i   (CLOCK_50),
    .reset_i (reset),
    .push_i  (peak_valid),
    .pop_i   (pop),
    .wdata_i (wframe),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    rd_req    = chipselect && read;
    status_rd = rd_req && (address == ADDR_STATUS);
    data_rd   = rd_req && (address == ADDR_DATA) && !empty;
    pop       = data_rd && (idx_q == IDX_W'(PEAKS));
    // A pop in the same cycle frees the slot, so the frame is not dropped.
    drop      = peak_valid && full && !pop;

    idx_d = idx_q;
    if (data_rd) idx_d = pop ? '0 : idx_q + IDX_W'(1);

    ovf_d = drop || (ovf_q && !status_rd);

    rdata_d = rdata_q;
    if (status_rd) begin
      rdata_d        = '0;
      rdata_d[0]     = empty;
      rdata_d[1]     = ovf_q;
      rdata_d[2]     = full;
      rdata_d[15:8]  = 8'(count);
      rdata_d[23:16] = 8'(idx_q);
    end else if (rd_req) begin
      rdata_d = empty ? '0 : pack_word(head, idx_q);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      irq_q   <= !empty;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_peak_reader.sv
// Self-checking bench for peak_reader: directed tables, corner sequences and a random run.
module tb_peak_reader;
  import peaks_pkg::*;

  logic                         CLOCK_50 = 1'b0;
  logic                         reset = 1'b1;
  logic                         peak_valid = 1'b0;
  logic [PEAKS-1:0][AMPL_W-1:0] amplitudes_in = '0;
  logic [PEAKS-1:0][FREQ_W-1:0] freqs_in = '0;
  logic [TIME_W-1:0]            counter_in = '0;
  logic                         chipselect = 1'b0;
  logic                         read = 1'b0;
  logic                         address = 1'b0;
  logic [31:0]                  readdata;
  logic                         irq;

  peak_reader dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .peak_valid    (peak_valid),
    .amplitudes_in (amplitudes_in),
    .freqs_in      (freqs_in),
    .counter_in    (counter_in),
    .chipselect    (chipselect),
    .read          (read),
    .address       (address),
    .readdata      (readdata),
    .irq           (irq)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Reference model: queue of frames, each already flattened to its 7 output words.
  typedef logic [PEAKS:0][31:0] fwords_t;
  fwords_t mq[$];
  int      m_idx = 0;
  bit      m_ovf = 1'b0;

  task automatic do_reset();
    reset = 1'b1; peak_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    mq.delete(); m_idx = 0; m_ovf = 1'b0;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
  endtask

  // One clock: optional strobe (amps ab+k, freqs fb+k) and optional read at address a.
  task automatic cycle(input bit v, input logic [TIME_W-1:0] c, input logic [AMPL_W-1:0] ab,
                       input logic [FREQ_W-1:0] fb, input bit r, input bit a,
                       output logic [31:0] got);
    logic [31:0] exp;
    fwords_t     nf;
    bit          pop, drop, nonempty;
    peak_valid = v; counter_in = c;
    for (int k = 0; k < PEAKS; k++) begin
      amplitudes_in[k] = ab + AMPL_W'(k);
      freqs_in[k]      = fb + FREQ_W'(k);
    end
    chipselect = r; read = r; address = a;

    nonempty = (mq.size() != 0);
    exp = '0; pop = 1'b0; drop = 1'b0;
    if (r && !a) begin
      exp[0]     = (mq.size() == 0);
      exp[1]     = m_ovf;
      exp[2]     = (mq.size() == DEPTH);
      exp[15:8]  = 8'(mq.size());
      exp[23:16] = 8'(m_idx);
    end else if (r && a && mq.size() != 0) begin
      exp = mq[0][m_idx];
      m_idx++;
      if (m_idx == FRAME_WORDS) begin
        m_idx = 0;
        pop = 1'b1;
      end
    end
    nf = '0;
    nf[0] = 32'(c);
    for (int k = 0; k < PEAKS; k++) begin
      nf[k+1][AMPL_W-1:0]             = ab + AMPL_W'(k);
      nf[k+1][AMPL_W+FREQ_W-1:AMPL_W] = fb + FREQ_W'(k);
    end
    if (pop) void'(mq.pop_front());
    if (v) begin
      if (mq.size() < DEPTH) mq.push_back(nf);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (r && !a) m_ovf = 1'b0;

    @(posedge CLOCK_50); #1;
    got = readdata;
    if (r) check(a ? "data_read" : "status_read", readdata, exp);
    check("irq", 32'(irq), 32'(nonempty));
    peak_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
  endtask

  typedef struct {
    bit              v;
    logic [TIME_W-1:0] c;
    bit              r;
    bit              a;
    bit              chk;
    logic [31:0]     exp;
  } vec_t;

  vec_t        tbl[9];
  logic [31:0] got;

  initial begin
    // Single frame capture and full drain, with literal expected words.
    tbl[0] = '{v: 1'b1, c: 24'h000010, r: 1'b0, a: 1'b0, chk: 1'b0, exp: 32'h0};
    tbl[1] = '{v: 1'b0, c: 24'h0, r: 1'b1, a: 1'b1, chk: 1'b1, exp: 32'h00000010};
    for (int k = 0; k < PEAKS; k++)
      tbl[k+2] = '{v: 1'b0, c: 24'h0, r: 1'b1, a: 1'b1, chk: 1'b1,
                   exp: 32'h000A0064 + 32'h00010001 * 32'(k)};
    tbl[8] = '{v: 1'b0, c: 24'h0, r: 1'b1, a: 1'b0, chk: 1'b1, exp: 32'h00000001};

    do_reset();
    cycle(0, 0, 0, 0, 1, ADDR_STATUS, got);
    check("status_after_reset", got, 32'h00000001);
    cycle(0, 0, 0, 0, 1, ADDR_DATA, got);
    check("data_when_empty", got, 32'h0);

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].c, 16'd100, 10'd10, tbl[i].r, tbl[i].a, got);
      if (tbl[i].chk) check("tbl_single_frame", got, tbl[i].exp);
    end
    check("irq_after_drain", 32'(irq), 32'h0);

    // Overflow: five strobes into a four-slot buffer.
    for (int i = 0; i < 5; i++) cycle(1, 24'h100 + 24'(i), 16'(i * 7), 10'(i), 0, 0, got);
    cycle(0, 0, 0, 0, 1, ADDR_STATUS, got);
    check("status_overflow", got, 32'h00000406);
    cycle(0, 0, 0, 0, 1, ADDR_STATUS, got);
    check("status_ovf_cleared", got, 32'h00000404);
    for (int i = 0; i < 4 * FRAME_WORDS; i++) begin
      cycle(0, 0, 0, 0, 1, ADDR_DATA, got);
      if (i % FRAME_WORDS == 0) check("drained_counter", got, 32'h100 + 32'(i / FRAME_WORDS));
    end

    // Full buffer with a push on the same cycle as the head frame's last word.
    for (int i = 0; i < 4; i++) cycle(1, 24'h200 + 24'(i), 16'h1000, 10'h20, 0, 0, got);
    for (int i = 0; i < PEAKS; i++) cycle(0, 0, 0, 0, 1, ADDR_DATA, got);
    cycle(1, 24'h2FF, 16'h5555, 10'h155, 1, ADDR_DATA, got);
    cycle(0, 0, 0, 0, 1, ADDR_STATUS, got);
    check("status_push_pop_full", got, 32'h00000404);
    for (int i = 0; i < 4 * FRAME_WORDS; i++) begin
      cycle(0, 0, 0, 0, 1, ADDR_DATA, got);
      if (i == 3 * FRAME_WORDS) check("last_frame_counter", got, 32'h2FF);
    end

    // Reset in the middle of a drain.
    cycle(1, 24'h300, 16'h0042, 10'h3, 0, 0, got);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, ADDR_DATA, got);
    do_reset();
    cycle(0, 0, 0, 0, 1, ADDR_STATUS, got);
    check("status_after_mid_reset", got, 32'h00000001);
    cycle(1, 24'h301, 16'h0077, 10'h7, 0, 0, got);
    cycle(0, 0, 0, 0, 1, ADDR_DATA, got);
    check("word0_after_reset", got, 32'h301);
    for (int i = 1; i < FRAME_WORDS; i++) cycle(0, 0, 0, 0, 1, ADDR_DATA, got);

    // peak_valid held high for three consecutive cycles.
    for (int i = 1; i <= 3; i++) cycle(1, 24'(i), 16'(i * 100), 10'(i * 3), 0, 0, got);
    cycle(0, 0, 0, 0, 1, ADDR_STATUS, got);
    check("status_three_held", got, 32'h00000300);
    for (int i = 0; i < 3 * FRAME_WORDS; i++) begin
      cycle(0, 0, 0, 0, 1, ADDR_DATA, got);
      if (i % FRAME_WORDS == 0) check("held_counter", got, 32'(i / FRAME_WORDS + 1));
    end

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 2) == 0, TIME_W'($urandom), AMPL_W'($urandom), FREQ_W'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
